// File: rtl/not_32_pkg.sv
// Shared constants for the NOT-32 datapath slice.
package not_32_pkg;

    localparam int unsigned NOT32_WIDTH = 32;

    typedef logic [NOT32_WIDTH-1:0] word_t;

    localparam word_t NOT32_ZERO = '0;
    localparam word_t NOT32_ONES = '1;

endpackage : not_32_pkg

// File: rtl/not_32_reg_en.sv
// W-bit register with asynchronous active-high clear and load enable.
module not_32_reg_en #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when enabled; clear forces zero at once and overrides en.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : not_32_reg_en

// File: rtl/not_32.sv
// ALU NOT operation: combinational one's complement plus a registered
// copy and a captured-zero flag for the result-capture stage.
module not_32
    import not_32_pkg::*;
#(
    parameter int unsigned WIDTH = NOT32_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Ra,
    input  logic             Rin,
    output logic [WIDTH-1:0] Rb,
    output logic [WIDTH-1:0] Rb_q,
    output logic             Zq
);

    logic       rb_zero;
    logic [0:0] zq_vec;

    // Result is independent of clock/clear so it stays valid with no clock.
    assign Rb      = ~Ra;
    assign rb_zero = ~|Rb;
    assign Zq      = zq_vec[0];

    not_32_reg_en #(
        .W(WIDTH)
    ) u_rb_q (
        .clock(clock),
        .clear(clear),
        .en   (Rin),
        .d    (Rb),
        .q    (Rb_q)
    );

    // Zq clears to 0 (not "value is zero"); it flags a captured zero result.
    not_32_reg_en #(
        .W(1)
    ) u_zq (
        .clock(clock),
        .clear(clear),
        .en   (Rin),
        .d    (rb_zero),
        .q    (zq_vec)
    );

endmodule : not_32

// File: tb/tb_not_32.sv
// Self-checking bench for not_32: directed vectors plus a reference model.
`timescale 1ns/10ps
module tb_not_32;
    import not_32_pkg::*;

    logic        clock;
    logic        clear;
    logic [31:0] Ra;
    logic        Rin;
    logic [31:0] Rb;
    logic [31:0] Rb_q;
    logic        Zq;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model of the registered stage.
    logic [31:0] m_q;
    logic        m_z;
    logic        cmp_en = 1'b0;

    not_32 #(.WIDTH(32)) dut (
        .clock(clock),
        .clear(clear),
        .Ra   (Ra),
        .Rin  (Rin),
        .Rb   (Rb),
        .Rb_q (Rb_q),
        .Zq   (Zq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Complement computed arithmetically: all-ones minus the operand.
    function automatic logic [31:0] inv_of(input logic [31:0] a);
        return 32'hFFFF_FFFF - a;
    endfunction

    // One clock cycle; the model updates with the values seen at the edge.
    task automatic tick();
        if (clear) begin
            m_q = 32'h0;
            m_z = 1'b0;
        end else if (Rin) begin
            m_q = inv_of(Ra);
            m_z = (Ra == 32'hFFFF_FFFF);
        end
        clock = 1'b1;
        #5;
        clock = 1'b0;
        #5;
    endtask

    // Every falling edge: all outputs must match the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_rb",   Rb,   inv_of(Ra));
            chk("cyc_rb_q", Rb_q, m_q);
            chk("cyc_zq",   {31'b0, Zq}, {31'b0, m_z});
        end
    end

    initial begin
        logic [31:0] hold_q;
        logic        hold_z;

        // Combinational path with clock and clear never driven.
        Ra  = NOT32_ZERO;
        Rin = 1'b0;
        #10;
        chk("nc_rb_zero", Rb, 32'hFFFF_FFFF);
        Ra = NOT32_ONES;
        #10;
        chk("rb_ones", Rb, 32'h0000_0000);
        Ra = 32'hAAAA_AAAA;
        #10;
        chk("rb_aa", Rb, 32'h5555_5555);
        Ra = 32'h5555_5555;
        #10;
        chk("rb_55", Rb, 32'hAAAA_AAAA);

        // Asynchronous clear, no clock edge.
        clock = 1'b0;
        clear = 1'b1;
        #1;
        chk("clr_rb_q", Rb_q, 32'h0);
        chk("clr_zq",   {31'b0, Zq}, 32'h0);
        m_q = 32'h0;
        m_z = 1'b0;
        #9;
        clear  = 1'b0;
        cmp_en = 1'b1;

        // First load after clear.
        Ra  = 32'h0000_FFFF;
        Rin = 1'b1;
        #2;
        tick();
        chk("ld_rb_q", Rb_q, 32'hFFFF_0000);
        chk("ld_zq",   {31'b0, Zq}, 32'h0);

        // Capture a zero result.
        Ra = 32'hFFFF_FFFF;
        tick();
        chk("z_rb_q", Rb_q, 32'h0);
        chk("z_zq",   {31'b0, Zq}, 32'h1);

        // Hold with Rin low.
        Rin = 1'b0;
        Ra  = 32'h1234_5678;
        for (int unsigned i = 0; i < 3; i++) tick();
        chk("hold_rb_q", Rb_q, 32'h0);
        chk("hold_zq",   {31'b0, Zq}, 32'h1);
        chk("hold_rb",   Rb, 32'hEDCB_A987);

        // Load nonzero, then clear between edges while Rin=1.
        Rin = 1'b1;
        Ra  = 32'h0F0F_0000;
        tick();
        chk("pre_clr_rb_q", Rb_q, 32'hF0F0_FFFF);
        #2;
        clear = 1'b1;
        m_q   = 32'h0;
        m_z   = 1'b0;
        #1;
        chk("mid_clr_rb_q", Rb_q, 32'h0);
        chk("mid_clr_zq",   {31'b0, Zq}, 32'h0);
        Ra = 32'hFFFF_FFFF;
        for (int unsigned i = 0; i < 2; i++) tick();
        chk("clr_edge_rb_q", Rb_q, 32'h0);
        chk("clr_edge_zq",   {31'b0, Zq}, 32'h0);
        clear = 1'b0;
        Ra    = 32'h8000_0001;
        #2;
        tick();
        chk("resume_rb_q", Rb_q, 32'h7FFF_FFFE);

        // Randomized operands and load enables.
        for (int unsigned i = 0; i < 1000; i++) begin
            Ra  = $urandom;
            Rin = 1'($urandom_range(0, 1));
            if (i % 97 == 5) Ra = 32'hFFFF_FFFF;
            hold_q = m_q;
            hold_z = m_z;
            #2;
            chk("rnd_rb", Rb, inv_of(Ra));
            tick();
            if (!Rin) begin
                chk("rnd_hold", Rb_q, hold_q);
                chk("rnd_hold_z", {31'b0, Zq}, {31'b0, hold_z});
            end
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_not_32
